// File: rtl/multiphase_lo_gen.sv
// NCO-driven one-hot multiphase LO generator with wrap-synchronised frequency
// updates, sideband selection, optional break-before-make dead time and enable.
module multiphase_lo_gen #(
  parameter int PHASES   = 4,
  parameter int ACC_W    = 24,
  parameter int DEAD_CYC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic              freq_strobe,
  input  logic              sideband,
  output logic [PHASES-1:0] phase_out,
  output logic              freq_busy,
  output logic              wrap_pulse
);

  localparam int         IDX_W   = $clog2(PHASES);
  localparam logic [2:0] DEAD_LD = 3'(DEAD_CYC);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  inc_q, inc_d;
  logic [ACC_W-1:0]  pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              wrap_q, wrap_d;
  logic [PHASES-1:0] phase_q, phase_d;
  logic [PHASES-1:0] last_q, last_d;
  logic [PHASES-1:0] hold_q, hold_d;
  logic [2:0]        dead_q, dead_d;

  logic [ACC_W:0]    sum_s;
  logic              carry_s;
  logic [IDX_W-1:0]  idx_raw_s;
  logic [IDX_W-1:0]  idx_s;
  logic [PHASES-1:0] target_s;

  // Accumulator, frequency handshake and output/dead-time next-state logic
  always_comb begin
    sum_s     = {1'b0, acc_q} + {1'b0, inc_q};
    carry_s   = enable & sum_s[ACC_W];
    idx_raw_s = acc_q[ACC_W-1 -: IDX_W];
    if (sideband) begin
      idx_s = {IDX_W{1'b0}} - idx_raw_s;
    end else begin
      idx_s = idx_raw_s;
    end
    target_s = {{(PHASES-1){1'b0}}, 1'b1} << idx_s;

    acc_d   = acc_q;
    inc_d   = inc_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    phase_d = phase_q;
    last_d  = last_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    wrap_d  = carry_s;

    if (enable) begin
      acc_d = sum_s[ACC_W-1:0];
    end else begin
      acc_d = acc_q;
    end

    // With inc==0 or enable==0 no wrap can ever come, so apply at once
    if (busy_q) begin
      if (carry_s || (inc_q == {ACC_W{1'b0}}) || !enable) begin
        inc_d  = pend_q;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (freq_strobe) begin
      pend_d = freq_word;
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end

    if (!enable) begin
      phase_d = {PHASES{1'b0}};
      dead_d  = 3'd0;
    end else if (DEAD_CYC == 0) begin
      phase_d = target_s;
      last_d  = target_s;
    end else if (dead_q != 3'd0) begin
      if (target_s != hold_q) begin
        phase_d = {PHASES{1'b0}};
        dead_d  = DEAD_LD;
        hold_d  = target_s;
      end else if (dead_q == 3'd1) begin
        phase_d = target_s;
        last_d  = target_s;
        dead_d  = 3'd0;
      end else begin
        phase_d = {PHASES{1'b0}};
        dead_d  = dead_q - 3'd1;
      end
    end else if ((last_q != {PHASES{1'b0}}) && (target_s != last_q)) begin
      phase_d = {PHASES{1'b0}};
      dead_d  = DEAD_LD;
      hold_d  = target_s;
    end else begin
      phase_d = target_s;
      last_d  = target_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= {ACC_W{1'b0}};
      inc_q   <= {ACC_W{1'b0}};
      pend_q  <= {ACC_W{1'b0}};
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      phase_q <= {PHASES{1'b0}};
      last_q  <= {PHASES{1'b0}};
      hold_q  <= {PHASES{1'b0}};
      dead_q  <= 3'd0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      phase_q <= phase_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
    end
  end

  assign phase_out  = phase_q;
  assign freq_busy  = busy_q;
  assign wrap_pulse = wrap_q;

endmodule
